// File: rtl/seq_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and the
// default parallel word width.
package seq_pkg;

  localparam int SEQ_DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } seq_state_e;

  // Plain-vector aliases of the state encoding for RTL that keeps state
  // in a logic vector.
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SHIFT  = SHIFT;
  localparam logic [1:0] ST_PARITY = PARITY;

endpackage : seq_pkg

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter: one DATA_W word in, MSB-first bit stream out
// with a frame-valid flag and an end-of-frame pulse.
//
// Build option: define SEQ_SER_PARITY_EN to append an even-parity bit
// (XOR of the accepted word) after the LSB of every frame.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready is high in IDLE and in the final output cycle of a frame, so a
// word offered in that final cycle starts a gapless follow-on frame. While
// in_ready is low the source must hold in_valid/in_data stable; they are
// ignored. Reset wins over a simultaneous transfer (the word is dropped).
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   DATA_W   = SEQ_DATA_W_DEF,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              x,
  output logic              x_valid,
  output logic              frame_done,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(DATA_W - 2);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic              x_q, x_d;
  logic              xv_q, xv_d;
  logic              fd_q, fd_d;
  logic              last_cycle;
  logic              accept;

  // Final output cycle of a frame: the LSB, or the parity bit when enabled.
`ifdef SEQ_SER_PARITY_EN
  assign last_cycle = (state_q == ST_PARITY);
`else
  assign last_cycle = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
`endif

  assign in_ready    = (state_q == ST_IDLE) || last_cycle;
  assign accept      = in_valid && in_ready;
  assign x           = x_q;
  assign x_valid     = xv_q;
  assign frame_done  = fd_q;
  assign dbg_state_o = state_q;

  // Next-state logic: sh_q holds the bits still to be sent, left-aligned,
  // so the next bit is always sh_q[DATA_W-1].
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    x_d     = x_q;
    xv_d    = xv_q;
    fd_d    = 1'b0;
    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      sh_d    = {in_data[DATA_W-2:0], 1'b0};
      par_d   = ^in_data;
      x_d     = in_data[DATA_W-1];
      xv_d    = 1'b1;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (cnt_q == CNT_LAST) begin
`ifdef SEQ_SER_PARITY_EN
            state_d = ST_PARITY;
            x_d     = par_q;
            xv_d    = 1'b1;
            fd_d    = 1'b1;
`else
            state_d = ST_IDLE;
            x_d     = IDLE_BIT;
            xv_d    = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            x_d   = sh_q[DATA_W-1];
            sh_d  = {sh_q[DATA_W-2:0], 1'b0};
`ifndef SEQ_SER_PARITY_EN
            // The bit loaded now is the LSB, i.e. the last of the frame.
            fd_d  = (cnt_q == CNT_PENULT);
`endif
          end
        end
`ifdef SEQ_SER_PARITY_EN
        ST_PARITY: begin
          state_d = ST_IDLE;
          x_d     = IDLE_BIT;
          xv_d    = 1'b0;
        end
`endif
        default: begin
          state_d = ST_IDLE;
          x_d     = IDLE_BIT;
          xv_d    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; synchronous reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      x_q     <= IDLE_BIT;
      xv_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      fd_q    <= fd_d;
    end
  end

endmodule : seq_bit_serializer

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: directed frames plus a long
// randomized run, all compared cycle by cycle against a queue-based model
// of the expected output bit stream.
module tb_seq_bit_serializer;

  localparam int   DW       = 8;
  localparam logic IDLE_BIT = 1'b0;
`ifdef SEQ_SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = DW + (PAR ? 1 : 0);

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          x;
  logic          x_valid;
  logic          frame_done;
  logic [1:0]    dbg_state;

  seq_bit_serializer #(.DATA_W(DW), .IDLE_BIT(IDLE_BIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .x_valid    (x_valid),
    .frame_done (frame_done),
    .dbg_state_o(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: each entry is {last_of_frame, bit}; front is the bit on x now.
  logic [1:0] exp_q[$];

  // Observation of the DUT stream for directed checks
  logic [31:0] obs_bits;
  logic [31:0] rdy_hist;
  int          obs_n;
  int          fd_n;
  logic [3:0]  det;
  int          det_fill;
  int          det_hits;

  task automatic clear_obs();
    obs_bits = '0;
    rdy_hist = '0;
    obs_n    = 0;
    fd_n     = 0;
    det      = '0;
    det_fill = 0;
    det_hits = 0;
  endtask

  task automatic check_outputs();
    logic [1:0] f;
    logic       busy;
    busy = (exp_q.size() > 0);
    f    = busy ? exp_q[0] : 2'b00;
    check("in_ready",   32'(in_ready),   32'(exp_q.size() <= 1));
    check("x_valid",    32'(x_valid),    32'(busy));
    check("x",          32'(x),          32'(busy ? f[0] : IDLE_BIT));
    check("frame_done", 32'(frame_done), 32'(busy ? f[1] : 1'b0));
    if (x_valid === 1'b1) begin
      obs_bits = {obs_bits[30:0], x};
      rdy_hist = {rdy_hist[30:0], in_ready};
      obs_n++;
      if (frame_done === 1'b1) fd_n++;
      det = {det[2:0], x};
      det_fill++;
      if (det_fill >= 4 && det == 4'b1010) det_hits++;
    end
  endtask

  // Advance the model across one rising edge using the driven inputs.
  task automatic m_edge(output bit acc);
    logic lst;
    acc = !rst && in_valid && (exp_q.size() <= 1);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        for (int i = DW - 1; i >= 0; i--) begin
          lst = (i == 0) && !PAR;
          exp_q.push_back({lst, in_data[i]});
        end
        if (PAR) exp_q.push_back({1'b1, ^in_data});
      end
    end
  endtask

  // Driver: check at the falling edge, then cross one rising edge.
  task automatic cycle(output bit acc);
    check_outputs();
    @(posedge clk);
    m_edge(acc);
    @(negedge clk);
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle(a);
    if (exp_q.size() > 0) check("drain_timeout", 32'd0, 32'd1);
    cycle(a);
  endtask

  task automatic send_word(input string tag, input logic [DW-1:0] d, input logic [31:0] expv);
    bit a;
    bit got;
    clear_obs();
    in_valid = 1'b1;
    in_data  = d;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle(a);
      got = a;
    end
    if (!got) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    in_valid = 1'b0;
    drain();
    check({tag, "_bits"},  obs_bits,   expv);
    check({tag, "_nbits"}, 32'(obs_n), 32'(FL));
    check({tag, "_done"},  32'(fd_n),  32'd1);
  endtask

  initial begin
    bit a;
    bit got;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    clear_obs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.delete();

    // Reset state, with a word offered during reset (must be dropped)
    in_valid = 1'b1;
    in_data  = 8'h77;
    cycle(a);
    cycle(a);
    rst      = 1'b0;
    in_valid = 1'b0;
    cycle(a);

    // Single frames
`ifdef SEQ_SER_PARITY_EN
    send_word("a5", 8'hA5, 32'h14A);
    send_word("p07", 8'h07, 32'h00F);
    send_word("p03", 8'h03, 32'h006);
`else
    send_word("a5", 8'hA5, 32'h0A5);
    send_word("w07", 8'h07, 32'h007);
    send_word("w03", 8'h03, 32'h003);
`endif

    // Back-to-back with in_valid held high
    clear_obs();
    in_valid = 1'b1;
    in_data  = 8'hA0;
    cycle(a);
    in_data = 8'h0A;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle(a);
      got = a;
    end
    if (!got) check("b2b_accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    drain();
    check("b2b_nbits", 32'(obs_n), 32'(2 * FL));
`ifdef SEQ_SER_PARITY_EN
    check("b2b_bits", obs_bits, 32'h28014);
    check("b2b_ready", rdy_hist, 32'h00201);
`else
    check("b2b_bits", obs_bits, 32'hA00A);
    check("b2b_ready", rdy_hist, 32'h0101);
`endif
    check("b2b_done", 32'(fd_n), 32'd2);

    // Stall: word offered mid-frame waits for the final cycle
    clear_obs();
    in_valid = 1'b1;
    in_data  = 8'h3C;
    cycle(a);
    in_valid = 1'b0;
    cycle(a);
    cycle(a);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle(a);
      got = a;
    end
    if (!got) check("stall_accept_timeout", 32'd0, 32'd1);
    check("stall_accept_at", 32'(obs_n), 32'(FL));
    in_valid = 1'b0;
    drain();
`ifdef SEQ_SER_PARITY_EN
    check("stall_bits", obs_bits, 32'h0F1FE);
`else
    check("stall_bits", obs_bits, 32'h3CFF);
`endif

    // Mid-frame reset with a simultaneous offered word
    clear_obs();
    in_valid = 1'b1;
    in_data  = 8'hC3;
    cycle(a);
    in_valid = 1'b0;
    cycle(a);
    cycle(a);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    cycle(a);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mrst_x_valid", 32'(x_valid),    32'd0);
    check("mrst_done",    32'(frame_done), 32'd0);
    check("mrst_ready",   32'(in_ready),   32'd1);
    check("mrst_x",       32'(x),          32'(IDLE_BIT));
    repeat (4) cycle(a);
    check("mrst_nbits", 32'(obs_n), 32'd3);
    check("mrst_fd_n",  32'(fd_n),  32'd0);

    // Stream feeding a 1010 detector
`ifdef SEQ_SER_PARITY_EN
    send_word("d5a", 8'h5A, 32'h0B4);
`else
    send_word("d5a", 8'h5A, 32'h05A);
`endif
    check("det_hits", 32'(det_hits), 32'd1);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_data  = DW'($urandom);
      end
      cycle(a);
      if (a) in_valid = 1'b0;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seq_bit_serializer
